// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Holds the state enum, the opcode/funct values and the datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, IEXEC, IWB, BRANCH, JUMP, ILLEGAL, FAULT
  } state_t;

  // Selects which rule the ALU decoder applies in the current state.
  typedef enum logic [2:0] {
    ALU_CLS_NONE, ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_RTYPE, ALU_CLS_ITYPE
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Combinational ALU operation / extender decode.
// The FSM picks the rule class; this block resolves it against opcode and funct.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  alu_cls_t   alu_cls,
  output logic [2:0] alu_op,
  output logic       ext_sel,
  output logic       funct_ok
);

  always_comb begin
    alu_op   = ALU_AND;
    ext_sel  = 1'b1;
    funct_ok = 1'b0;

    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase

    case (alu_cls)
      ALU_CLS_ADD: alu_op = ALU_ADD;
      ALU_CLS_SUB: alu_op = ALU_SUB;
      ALU_CLS_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_AND;
        endcase
      end
      ALU_CLS_ITYPE: begin
        // Logical immediates use a zero-extended operand.
        case (opcode)
          OP_ANDI: begin
            alu_op  = ALU_AND;
            ext_sel = 1'b0;
          end
          OP_ORI: begin
            alu_op  = ALU_OR;
            ext_sel = 1'b0;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute, handshakes with
// memory, and traps illegal instructions and bus timeouts.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_sel,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error
);

  state_t             r_state;
  state_t             w_next;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               w_tmo_hit;
  alu_cls_t           w_alu_cls;
  logic [2:0]         w_alu_op;
  logic               w_ext_sel;
  logic               w_funct_ok;

  // A ready in the limit cycle still completes the access.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(MEM_TIMEOUT)) && !mem_ready;

  always_comb begin
    case (r_state)
      FETCH, DECODE, MEMADR: w_alu_cls = ALU_CLS_ADD;
      EXEC:                  w_alu_cls = ALU_CLS_RTYPE;
      IEXEC:                 w_alu_cls = ALU_CLS_ITYPE;
      BRANCH:                w_alu_cls = ALU_CLS_SUB;
      default:               w_alu_cls = ALU_CLS_NONE;
    endcase
  end

  mips_alu_decode u_alu_decode (
    .opcode   (opcode),
    .funct    (funct),
    .alu_cls  (w_alu_cls),
    .alu_op   (w_alu_op),
    .ext_sel  (w_ext_sel),
    .funct_ok (w_funct_ok)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = FETCH;
      FETCH: begin
        if (mem_ready)      w_next = DECODE;
        else if (w_tmo_hit) w_next = FAULT;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:                 w_next = EXEC;
          OP_LW, OP_SW:             w_next = MEMADR;
          OP_BEQ:                   w_next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = IEXEC;
          OP_J:                     w_next = JUMP;
          default:                  w_next = ILLEGAL;
        endcase
      end
      MEMADR: w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)      w_next = MEMWB;
        else if (w_tmo_hit) w_next = FAULT;
      end
      MEMWR: begin
        if (mem_ready)      w_next = FETCH;
        else if (w_tmo_hit) w_next = FAULT;
      end
      EXEC:  w_next = w_funct_ok ? ALUWB : ILLEGAL;
      IEXEC: w_next = IWB;
      MEMWB, ALUWB, IWB, BRANCH, JUMP, ILLEGAL: w_next = FETCH;
      FAULT: w_next = FAULT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Only the wait states loop on themselves, so any transition starts a fresh count.
      if (w_next != r_state)
        r_tmo_cnt <= '0;
      else if (mem_req && !mem_ready)
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = w_alu_op;
    ext_sel    = w_ext_sel;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      DECODE: alu_src_b = SRCB_IMM_SH;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: alu_src_a = 1'b1;
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = PC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      FAULT: begin
        bus_error = 1'b1;
        ext_sel   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and random instruction streams with
// random memory wait states, checked per instruction against a latency/effect model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] R = 6'h00, J = 6'h02, BEQ = 6'h04, ADDI = 6'h08;
  localparam logic [5:0] ANDI = 6'h0C, ORI = 6'h0D, LW = 6'h23, SW = 6'h2B;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, ext_sel, reg_dst, mem_to_reg, reg_write;
  logic [2:0] alu_op;
  logic       instr_done, illegal, bus_error;

  int tests = 0;
  int fails = 0;
  int waitq[$];
  bit acc_active = 0;
  int acc_wait = 0;
  bit stuck = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_sel(ext_sel), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] all_outs();
    return {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
            alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal, bus_error};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: each access takes its planned number of wait cycles, then ready.
  task automatic drive_ready();
    if (stuck) begin
      mem_ready = 1'b0;
    end else if (mem_req) begin
      if (!acc_active) begin
        acc_wait   = (waitq.size() > 0) ? waitq.pop_front() : 0;
        acc_active = 1;
      end
      if (acc_wait > 0) begin
        mem_ready = 1'b0;
        acc_wait--;
      end else begin
        mem_ready  = 1'b1;
        acc_active = 0;
      end
    end else begin
      mem_ready = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int dw);
    int lat, wr, dst, m2r, ealu, eext, npcen, nmreq, nmwr, ill, endsrc, endpcen;
    int cyc, n_rw, n_pcen, n_irw, n_mreq, n_mwr, n_ill, n_done;
    logic [2:0] prev_alu, pre_alu;
    logic prev_ext, pre_ext, rw_dst, rw_m2r, e_pcen;
    logic [1:0] e_src;
    logic [8:0] fetch1;
    bit ended;
    string nm;

    lat = 0; wr = 0; dst = 0; m2r = 0; ealu = 0; eext = 1; npcen = 1;
    nmreq = fw + 1; nmwr = 0; ill = 0; endsrc = 0; endpcen = 0;
    case (op)
      R: begin
        lat = 4;
        case (fn)
          6'h20: begin wr = 1; ealu = 2; end
          6'h22: begin wr = 1; ealu = 6; end
          6'h24: begin wr = 1; ealu = 0; end
          6'h25: begin wr = 1; ealu = 1; end
          6'h2A: begin wr = 1; ealu = 7; end
          default: ill = 1;
        endcase
        dst = 1;
      end
      LW:   begin lat = 5 + dw; wr = 1; m2r = 1; nmreq += dw + 1; end
      SW:   begin lat = 4 + dw; nmwr = dw + 1; nmreq += dw + 1; end
      BEQ:  begin lat = 3; npcen += int'(z); endsrc = 1; endpcen = int'(z); end
      J:    begin lat = 3; npcen += 1; endsrc = 2; endpcen = 1; end
      ADDI: begin lat = 4; wr = 1; ealu = 2; eext = 1; end
      ANDI: begin lat = 4; wr = 1; ealu = 0; eext = 0; end
      ORI:  begin lat = 4; wr = 1; ealu = 1; eext = 0; end
      default: begin lat = 3; ill = 1; end
    endcase
    lat += fw;

    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z;
    waitq.push_back(fw);
    if (op == LW || op == SW) waitq.push_back(dw);

    cyc = 0; n_rw = 0; n_pcen = 0; n_irw = 0; n_mreq = 0; n_mwr = 0; n_ill = 0; n_done = 0;
    prev_alu = '0; pre_alu = '0; prev_ext = 1'b0; pre_ext = 1'b0; rw_dst = 1'b0;
    rw_m2r = 1'b0; e_pcen = 1'b0; e_src = '0; fetch1 = '0; ended = 0;
    while (!ended && cyc < 64) begin
      @(negedge clk);
      drive_ready();
      #1;
      cyc++;
      if (cyc == 1) fetch1 = {mem_req, iord, alu_src_a, alu_src_b, alu_op, pc_src[0]};
      n_rw   += int'(reg_write);
      n_pcen += int'(pc_en);
      n_irw  += int'(ir_write);
      n_mreq += int'(mem_req);
      n_mwr  += int'(mem_write);
      n_ill  += int'(illegal);
      n_done += int'(instr_done);
      if (reg_write) begin
        pre_alu = prev_alu; pre_ext = prev_ext; rw_dst = reg_dst; rw_m2r = mem_to_reg;
      end
      prev_alu = alu_op;
      prev_ext = ext_sel;
      if (instr_done || illegal) begin
        ended = 1; e_pcen = pc_en; e_src = pc_src;
      end
    end

    nm = $sformatf("op%02h_fn%02h_z%0d_fw%0d_dw%0d", op, fn, z, fw, dw);
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " fetch_sigs"}, {23'd0, fetch1}, {23'd0, 9'b1_0_0_01_010_0});
    chk({nm, " done_cnt"}, n_done, 1 - ill);
    chk({nm, " illegal_cnt"}, n_ill, ill);
    chk({nm, " reg_write_cnt"}, n_rw, wr);
    chk({nm, " pc_en_cnt"}, n_pcen, npcen);
    chk({nm, " ir_write_cnt"}, n_irw, 1);
    chk({nm, " mem_req_cyc"}, n_mreq, nmreq);
    chk({nm, " mem_write_cyc"}, n_mwr, nmwr);
    chk({nm, " end_pc_src"}, e_src, endsrc);
    chk({nm, " end_pc_en"}, e_pcen, endpcen);
    chk({nm, " bus_error"}, bus_error, 0);
    if (wr == 1) begin
      chk({nm, " reg_dst"}, rw_dst, dst);
      chk({nm, " mem_to_reg"}, rw_m2r, m2r);
      if (op != LW) begin
        chk({nm, " alu_op"}, pre_alu, ealu);
        chk({nm, " ext_sel"}, pre_ext, eext);
      end
    end
    $display("[TB] instr %s cycles=%0d writes=%0d illegal=%0d", nm, cyc, n_rw, n_ill);
  endtask

  initial begin : main
    logic [5:0] ops[9];
    logic [5:0] fns[8];
    logic [5:0] bad_ops[3];
    logic [5:0] op, fn;
    int n, req_cyc;
    bit got;

    ops = '{R, LW, SW, BEQ, ADDI, ANDI, ORI, J, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00, 6'h3F};
    bad_ops = '{6'h3F, 6'h01, 6'h10};

    // Reset held low, then released: IDLE outputs stay 0.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    reset_n = 1'b1;
    #1;
    chk("idle_outs", all_outs(), 0);

    run_instr(R, 6'h20, 0, 0, 0);
    run_instr(LW, 6'h00, 0, 0, 3);
    run_instr(BEQ, 6'h00, 1, 0, 0);
    run_instr(BEQ, 6'h00, 0, 0, 0);
    run_instr(ANDI, 6'h00, 0, 0, 0);
    run_instr(ADDI, 6'h00, 0, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0, 0);
    run_instr(SW, 6'h00, 0, 1, 2);
    run_instr(ADDI, 6'h00, 0, 15, 0);
    run_instr(LW, 6'h00, 0, 2, 15);

    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 8)];
      if (op == 6'h3F) op = bad_ops[$urandom_range(0, 2)];
      fn = fns[$urandom_range(0, 7)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Fetch that never completes: 16 waiting cycles, then FAULT.
    @(posedge clk);
    #1;
    stuck = 1; opcode = ADDI;
    n = 0; req_cyc = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      drive_ready();
      #1;
      n++;
      if (bus_error) got = 1;
      else if (mem_req) req_cyc++;
    end
    chk("fault_reached", got, 1);
    chk("fault_wait_cycles", req_cyc, 16);
    chk("fault_cycle", n, 17);
    stuck = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("fault_sticky_%0d", k), all_outs(), 17'd1);
    end
    $display("[TB] fault after %0d cycles, %0d waits", n, req_cyc);

    reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_clears_fault", all_outs(), 0);
    waitq.delete(); acc_active = 0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Store caught mid-wait by an asynchronous reset.
    @(posedge clk);
    #1;
    opcode = SW;
    waitq.push_back(0);
    waitq.push_back(5);
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      drive_ready();
      #1;
      n++;
      if (mem_write) got = 1;
    end
    chk("memwr_reached", got, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_mem_write", {mem_req, mem_write, instr_done}, 0);
    chk("async_reset_outs", all_outs(), 0);
    $display("[TB] async reset in MEMWR after %0d cycles", n);
    waitq.delete(); acc_active = 0; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    run_instr(LW, 6'h00, 0, 1, 1);
    run_instr(R, 6'h2A, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
